serial_bit_adder: RTL and testbench

- Bit-serial adder: adds two WIDTH-bit unsigned operands LSB-first, one bit per clock.
- Per-bit datapath is the team's half-adder pair plus a registered carry, i.e. the sequential stage built directly on the half-adder cell.
- Operands load on a start pulse; the result appears with a one-cycle done pulse and is held until the next start.
- Use: area-constrained accumulation paths where the parallel ripple adder is too large.

---
 rtl/serial_bit_adder.sv | 132 +++++++++++++
 tb/tb_serial_bit_adder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_bit_adder.sv
// serial_bit_adder
//   Bit-serial unsigned adder. Two WIDTH-bit operands are latched on a start
//   pulse and summed LSB-first, one bit per clock, through a half-adder pair
//   with a registered carry. The result is presented with a one-cycle done
//   pulse and held until the next operation completes.
//
//   Optional feature macro: SERIAL_BIT_ADDER_OVF_EN adds the ovf output
//   (two's-complement overflow of the addition).
//
// Parameters
//   WIDTH  operand and sum width in bits (2..32), default 8
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   load request, honoured only in IDLE
//   a, b   in   operands, sampled with start
//   busy   out  high while the serial addition is running
//   done   out  one-cycle pulse when sum/cout are updated
//   sum    out  result, held between operations
//   cout   out  carry out of the MSB, held with sum
//   ovf    out  signed overflow, held with sum (SERIAL_BIT_ADDER_OVF_EN only)

module serial_bit_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_BIT_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only WIDTH-1 bits are stored; the final bit goes straight into sum.
  logic [WIDTH-2:0] sum_sr;
  logic [CW-1:0]    cnt;
  logic             carry;

  // Half-adder pair: first cell adds the operand bits, second adds the carry.
  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic bit_s, carry_next;
  logic [WIDTH-1:0] sum_next;

  always_comb begin
    ha0_s      = a_sr[0] ^ b_sr[0];
    ha0_c      = a_sr[0] & b_sr[0];
    ha1_s      = ha0_s ^ carry;
    ha1_c      = ha0_s & carry;
    bit_s      = ha1_s;
    carry_next = ha0_c | ha1_c;
    sum_next   = {bit_s, sum_sr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_BIT_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next[WIDTH-1:1];
          carry  <= carry_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= sum_next;
            cout  <= carry_next;
`ifdef SERIAL_BIT_ADDER_OVF_EN
            // carry here is the carry into the MSB position
            ovf   <= carry ^ carry_next;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_adder.sv
// tb_serial_bit_adder
//   Self-checking bench for serial_bit_adder at WIDTH=8: directed cases plus
//   randomized operations with ignored start pulses, checked against
//   {cout, sum} = a + b computed arithmetically.

module tb_serial_bit_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_BIT_ADDER_OVF_EN
  logic         ovf;
`endif

  int unsigned vectors;
  int unsigned miscompares;

  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_ovf;

  serial_bit_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_BIT_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_BIT_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  // One full operation: start sampled at relative edge 0, then start is
  // driven from smask[i] before edge i (1..9) -- all of those must be ignored.
  // Operand inputs are scrambled after edge 0 to show they are not resampled.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [9:0] smask);
    logic [W:0] full;
    full  = {1'b0, x} + {1'b0, y};
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    chk("busy_e0", 32'(busy), 32'd1);
    chk("done_e0", 32'(done), 32'd0);
    for (int i = 1; i < int'(W); i++) begin
      start = smask[i];
      a     = W'($urandom);
      b     = W'($urandom);
      tick();
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk_held("held_run");
    end
    start = smask[W];
    tick();
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    exp_ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    chk("done_rise", 32'(done), 32'd1);
    chk("busy_fall", 32'(busy), 32'd0);
    chk_held("result");
    start = smask[W+1];
    tick();
    start = 1'b0;
    chk("done_fall", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk_held("held_idle");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_sum     = '0;
    exp_cout    = 1'b0;
    exp_ovf     = 1'b0;
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1 rst = 1'b1;
    #11;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_held("rst");
    rst = 1'b0;
    tick();

    // Basic additions, including carry out and a result returning to zero.
    do_op(8'h0F, 8'h01, '0);
    do_op(8'hFF, 8'h01, '0);
    do_op(8'h00, 8'h00, '0);

    // start re-asserted (with new operands) during run cycles 2 and 8.
    do_op(8'hAA, 8'h55, 10'b01_0000_0100);

    // Signed overflow cases.
    do_op(8'h7F, 8'h01, '0);
    do_op(8'h80, 8'h80, '0);

    // Reset in the middle of an operation: partial result discarded.
    a = 8'h12; b = 8'h34; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    chk_held("mid_rst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    do_op(8'h03, 8'h04, '0);

    // Back-to-back operations with random operands and random ignored starts.
    for (int n = 0; n < 24; n++)
      do_op(W'($urandom), W'($urandom), 10'($urandom) & 10'h3FE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
